fft_reorder_buf: RTL and testbench
==================================

Name: fft_reorder_buf

Overview:
Parametrised output reorder stage for the radix-2^2 SDF FFT cores (fft_16p and its larger-N successors).
- Accepts frames of N = 2^LOG2N complex samples in bit-reversed order and emits them in natural order.
- Uses a two-bank ping-pong buffer with downstream backpressure, frame-last marking and overflow reporting.
- Sits directly after the FFT core's o_valid/o_re/o_im stream.

Parameters:
- LOG2N, 4, log2 of frame length N (supported 2..10).
- DW, 16, width of each real/imaginary component (two's complement, passed through unmodified).
- BITREV_IN, 1: 1 = input is bit-reversed and is reordered to natural order; 0 = frame FIFO, order preserved.

Ports:
- clk  in  1  clock, all logic on rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_valid  in  1  input sample present
- i_re  in  DW  input real part
- i_im  in  DW  input imaginary part
- i_ready  in  1  downstream accepts the output sample this cycle
- o_valid  out  1  output sample valid (registered)
- o_re  out  DW  output real part (registered)
- o_im  out  DW  output imaginary part (registered)
- o_last  out  1  high with the final (index N-1) sample of each output frame
- o_busy  out  1  write bank full, input not accepted (combinational from state flags)
- o_overflow  out  1  sticky: a sample was offered while o_busy was high

Behaviour:
Reset:
- Asserting i_reset_n low at any time, including mid-frame, clears all outputs to 0: o_valid, o_re, o_im, o_last, o_busy, o_overflow.
- Reset also zeroes both bank-full flags, wr_cnt, rd_cnt, wr_bank and rd_bank.
- Memory contents are not cleared and are don't-care.

Storage:
- 2 banks x N entries x 2*DW bits.
- Register array with combinational read.

Write side:
- Accept when i_valid && !o_busy.
- Write address = bitrev(wr_cnt) when BITREV_IN=1, else wr_cnt.
- wr_cnt increments on each accepted sample. Gaps in i_valid hold wr_cnt; there is no timeout.
- On accepting the sample with wr_cnt = N-1: wr_cnt wraps to 0, full[wr_bank] is set and wr_bank toggles.

o_busy / o_overflow:
- o_busy = full[wr_bank].
- While o_busy is high, i_valid samples are dropped and o_overflow is set (sticky until reset).

Read side:
- The output register loads when (!o_valid || i_ready) && full[rd_bank]: o_re/o_im <= mem[rd_bank][rd_cnt], o_last <= (rd_cnt == N-1), o_valid <= 1, and rd_cnt increments.
- On loading rd_cnt = N-1: rd_cnt wraps, full[rd_bank] clears and rd_bank toggles.
- If no load occurs and i_ready is high, o_valid <= 0.
- With o_valid && !i_ready, o_re/o_im/o_last hold.

Latency:
- Last sample of a frame accepted at edge T gives first output (index 0) valid after edge T+1.
- Throughput is 1 sample/cycle. Continuous input with i_ready=1 produces gapless output and never raises o_busy.

Simultaneous events:
- The read side freeing a bank and the write side filling the other in the same cycle both take effect.
- o_busy reflects the new flags the next cycle.
- The read side continues into the next full bank with no bubble.
- A write completing into a bank that the read side frees in the same edge is impossible: the write bank is never the read bank while full.

Decomposition:
- Shared package fft_pkg: DW default, a LOG2N-bit bit-reverse function, and the complex-sample packing macro/typedef {re, im} shared with the FFT core.
- One sub-module is natural: fft_pingpong_ram (2 x N x 2*DW register array, one write port, one combinational read port, bank-select inputs).

Test Plan:
1. Single frame, LOG2N=4, i_ready=1: input position j carries re=bitrev(j), im=-bitrev(j) -> outputs re=0..15, im=0..-15 consecutive; o_valid first high one cycle after 16th accept; o_last only with re=15.
2. Three frames back-to-back, i_ready=1 -> 48 gapless outputs, each frame naturally ordered; o_busy and o_overflow stay 0.
3. i_ready=0; send 2 full frames -> o_busy=1 after 2nd frame's last accept. Then offer 1 sample -> dropped, o_overflow=1. o_valid=1 holding frame-0 element 0. Raise i_ready -> 32 correct outputs, and o_busy falls after frame 0 drains.
4. Frame with i_valid low for 5 cycles after sample 7, then remaining 9 samples -> wr_cnt holds; output frame correct and complete; no output before 16th accept.
5. Assert i_reset_n low after 7 samples of a frame -> all outputs 0 while low. After release, a fresh 16-sample frame -> correct natural-order output, no residue from the aborted frame.
6. BITREV_IN=0, LOG2N=3, input re=10..17 -> output re=10..17 unchanged order, o_last with 17.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sample width, complex packing and bit reversal.
package fft_pkg;
   localparam int DW_DEF    = 16;
   localparam int LOG2N_MAX = 10;

   // Complex sample packing shared with the FFT core: {re, im}.
   typedef struct packed {
      logic [DW_DEF-1:0] re;
      logic [DW_DEF-1:0] im;
   } cplx_t;

   // Reverse the low n bits of v; bits at and above n come back as zero.
   function automatic logic [LOG2N_MAX-1:0] bitrev(input logic [LOG2N_MAX-1:0] v,
                                                   input int n);
      logic [LOG2N_MAX-1:0] r;
      logic [LOG2N_MAX-1:0] t;
      r = '0;
      t = v;
      for (int i = 0; i < LOG2N_MAX; i++) begin
         if (i < n) begin
            r = {r[LOG2N_MAX-2:0], t[0]};
            t = t >> 1;
         end
      end
      return r;
   endfunction
endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store: one synchronous write port, one combinational read port.
module fft_pingpong_ram #(
   parameter int AW = 4,
   parameter int W  = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic          wr_bank,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_bank,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);
   logic [W-1:0] mem [2][2**AW];

   // Storage is never reset; the full flags decide what is meaningful.
   always_ff @(posedge clk) begin
      if (we) mem[wr_bank][wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_bank][rd_addr];
endmodule

// File: rtl/fft_reorder_buf.sv
// Ping-pong reorder stage: bit-reversed FFT frames in, natural-order frames out.
module fft_reorder_buf
   import fft_pkg::*;
#(
   parameter int LOG2N     = 4,
   parameter int DW        = DW_DEF,
   parameter int BITREV_IN = 1
) (
   input  logic          clk,
   input  logic          i_reset_n,
   input  logic          i_valid,
   input  logic [DW-1:0] i_re,
   input  logic [DW-1:0] i_im,
   input  logic          i_ready,
   output logic          o_valid,
   output logic [DW-1:0] o_re,
   output logic [DW-1:0] o_im,
   output logic          o_last,
   output logic          o_busy,
   output logic          o_overflow
);
   localparam int N = 2**LOG2N;

   typedef struct packed {
      logic [DW-1:0] re;
      logic [DW-1:0] im;
   } samp_t;

   logic [1:0]       full, full_nxt;
   logic [LOG2N-1:0] wr_cnt, rd_cnt, wr_addr;
   logic             wr_bank, rd_bank;
   logic             acc, wr_done, ld, rd_done;
   samp_t            wr_s, rd_s;

   // A bank only accepts writes once the reader has released it.
   assign o_busy  = full[wr_bank];
   assign acc     = i_valid && !o_busy;
   assign wr_done = acc && (wr_cnt == LOG2N'(N-1));
   assign ld      = (!o_valid || i_ready) && full[rd_bank];
   assign rd_done = ld && (rd_cnt == LOG2N'(N-1));
   assign wr_addr = (BITREV_IN != 0) ? LOG2N'(bitrev(LOG2N_MAX'(wr_cnt), LOG2N)) : wr_cnt;
   assign wr_s    = {i_re, i_im};

   fft_pingpong_ram #(.AW(LOG2N), .W(2*DW)) u_ram (
      .clk     (clk),
      .we      (acc),
      .wr_bank (wr_bank),
      .wr_addr (wr_addr),
      .wr_data (wr_s),
      .rd_bank (rd_bank),
      .rd_addr (rd_cnt),
      .rd_data (rd_s)
   );

   // Writer fills one bank while the reader frees the other; both may land on one edge.
   always_comb begin
      full_nxt = full;
      if (wr_done) full_nxt[wr_bank] = 1'b1;
      if (rd_done) full_nxt[rd_bank] = 1'b0;
   end

   // Write-side counters, bank flags and sticky overflow.
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         full       <= '0;
         wr_cnt     <= '0;
         wr_bank    <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         full <= full_nxt;
         if (acc) wr_cnt <= wr_cnt + 1'b1;
         if (wr_done) wr_bank <= ~wr_bank;
         if (i_valid && o_busy) o_overflow <= 1'b1;
      end
   end

   // Output register: refill whenever empty or being consumed, hold under backpressure.
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_valid <= 1'b0;
         o_re    <= '0;
         o_im    <= '0;
         o_last  <= 1'b0;
         rd_cnt  <= '0;
         rd_bank <= 1'b0;
      end else if (ld) begin
         o_valid <= 1'b1;
         o_re    <= rd_s.re;
         o_im    <= rd_s.im;
         o_last  <= (rd_cnt == LOG2N'(N-1));
         rd_cnt  <= rd_cnt + 1'b1;
         if (rd_done) rd_bank <= ~rd_bank;
      end else if (i_ready) begin
         o_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fft_reorder_buf.sv
// Self-checking bench: random frames against a queue-based natural-order model.
module tb_fft_reorder_buf;
   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid, i_ready, o_valid, o_last, o_busy, o_overflow;
   logic [15:0] i_re, i_im, o_re, o_im;
   logic        b_valid, b_ready, bo_valid, bo_last, bo_busy, bo_overflow;
   logic [15:0] b_re, b_im, bo_re, bo_im;

   int total = 0;
   int bad   = 0;
   bit chk_no_busy = 1'b0;

   typedef struct {
      logic [15:0] re;
      logic [15:0] im;
      logic        last;
   } exp_t;

   exp_t q[$];
   exp_t q2[$];
   exp_t e1, e2;

   always #5 clk = ~clk;

   fft_reorder_buf #(.LOG2N(4), .DW(16), .BITREV_IN(1)) dut (
      .clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .i_re(i_re), .i_im(i_im),
      .i_ready(i_ready), .o_valid(o_valid), .o_re(o_re), .o_im(o_im),
      .o_last(o_last), .o_busy(o_busy), .o_overflow(o_overflow)
   );

   fft_reorder_buf #(.LOG2N(3), .DW(16), .BITREV_IN(0)) dut_fifo (
      .clk(clk), .i_reset_n(rst_n), .i_valid(b_valid), .i_re(b_re), .i_im(b_im),
      .i_ready(b_ready), .o_valid(bo_valid), .o_re(bo_re), .o_im(bo_im),
      .o_last(bo_last), .o_busy(bo_busy), .o_overflow(bo_overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reverse the low 'bits' bits of v by repeated halving.
   function automatic int rev(input int v, input int bits);
      int r = 0;
      int t = v;
      for (int b = 0; b < bits; b++) begin
         r = r * 2 + (t % 2);
         t = t / 2;
      end
      return r;
   endfunction

   // Natural-order output k of a frame is the sample that arrived at position rev(k).
   task automatic send_frame(input int kind, input int gap_at, input int gap_len);
      logic [15:0] ra[N];
      logic [15:0] ia[N];
      for (int j = 0; j < N; j++) begin
         if (kind == 1) begin
            ra[j] = 16'(rev(j, 4));
            ia[j] = 16'(-rev(j, 4));
         end else begin
            ra[j] = 16'($urandom);
            ia[j] = 16'($urandom);
         end
         i_valid = 1'b1;
         i_re    = ra[j];
         i_im    = ia[j];
         @(posedge clk); #1;
         if (j == gap_at) begin
            i_valid = 1'b0;
            for (int g = 0; g < gap_len; g++) begin
               @(negedge clk);
               chk("gap_no_out", o_valid, 0);
               @(posedge clk); #1;
            end
         end
      end
      for (int k = 0; k < N; k++)
         q.push_back('{re: ra[rev(k, 4)], im: ia[rev(k, 4)], last: (k == N-1)});
   endtask

   task automatic drain(input int max);
      int c = 0;
      while ((q.size() != 0 || q2.size() != 0) && c < max) begin
         @(posedge clk);
         c++;
      end
      chk("drain_timeout", q.size() + q2.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Consumed outputs of the reorder instance are compared against the model queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (chk_no_busy) chk("no_busy", o_busy, 0);
         if (o_valid && i_ready) begin
            if (q.size() == 0) chk("spurious_out", o_valid, 0);
            else begin
               e1 = q.pop_front();
               chk("out_re", o_re, e1.re);
               chk("out_im", o_im, e1.im);
               chk("out_last", o_last, e1.last);
            end
         end
      end
   end

   // Same for the order-preserving instance.
   always @(negedge clk) begin
      if (rst_n && bo_valid && b_ready) begin
         if (q2.size() == 0) chk("fifo_spurious", bo_valid, 0);
         else begin
            e2 = q2.pop_front();
            chk("fifo_re", bo_re, e2.re);
            chk("fifo_im", bo_im, e2.im);
            chk("fifo_last", bo_last, e2.last);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      rst_n = 1'b0;
      i_valid = 1'b0; i_re = '0; i_im = '0; i_ready = 1'b1;
      b_valid = 1'b0; b_re = '0; b_im = '0; b_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", o_valid, 0);
      chk("rst_re", o_re, 0);
      chk("rst_im", o_im, 0);
      chk("rst_last", o_last, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_ovf", o_overflow, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single directed frame, latency
      chk_no_busy = 1'b1;
      send_frame(1, -1, 0);
      i_valid = 1'b0;
      @(negedge clk);
      chk("lat_pre", o_valid, 0);
      @(negedge clk);
      chk("lat_first", o_valid, 1);
      @(posedge clk); #1;
      drain(100);

      // three frames back to back
      repeat (3) send_frame(0, -1, 0);
      i_valid = 1'b0;
      drain(200);
      chk("no_overflow", o_overflow, 0);
      chk_no_busy = 1'b0;

      // backpressure, both banks full, overflow
      i_ready = 1'b0;
      send_frame(0, -1, 0);
      send_frame(0, -1, 0);
      i_valid = 1'b0;
      @(negedge clk);
      chk("busy_full", o_busy, 1);
      chk("hold_valid", o_valid, 1);
      chk("hold_re", o_re, q[0].re);
      chk("hold_im", o_im, q[0].im);
      @(posedge clk); #1;
      i_valid = 1'b1;
      i_re = 16'($urandom);
      i_im = 16'($urandom);
      @(posedge clk); #1;
      i_valid = 1'b0;
      @(negedge clk);
      chk("ovf_set", o_overflow, 1);
      chk("busy_still", o_busy, 1);
      i_ready = 1'b1;
      c = 0;
      while (q.size() > N && c < 100) begin
         @(posedge clk); #2;
         c++;
      end
      chk("busy_fall", o_busy, 0);
      drain(200);
      chk("ovf_sticky", o_overflow, 1);

      // input gap mid-frame
      send_frame(0, 6, 5);
      i_valid = 1'b0;
      drain(100);

      // reset mid-frame
      for (int j = 0; j < 7; j++) begin
         i_valid = 1'b1;
         i_re = 16'($urandom);
         i_im = 16'($urandom);
         @(posedge clk); #1;
      end
      i_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", o_valid, 0);
      chk("mid_rst_re", o_re, 0);
      chk("mid_rst_im", o_im, 0);
      chk("mid_rst_last", o_last, 0);
      chk("mid_rst_busy", o_busy, 0);
      chk("mid_rst_ovf", o_overflow, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_frame(0, -1, 0);
      i_valid = 1'b0;
      drain(100);

      // order-preserving 8-sample instance
      for (int j = 0; j < 8; j++) begin
         b_valid = 1'b1;
         b_re = 16'(10 + j);
         b_im = 16'($urandom);
         q2.push_back('{re: b_re, im: b_im, last: (j == 7)});
         @(posedge clk); #1;
      end
      b_valid = 1'b0;
      drain(100);
      chk("fifo_ovf", bo_overflow, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
